// File: rtl/sort_result_drain.sv
// sort_result_drain
//   Turns the parallel sorted result of serial_sorter back into a serial
//   valid/ready stream of (value, index) pairs, one pair per cycle. When a
//   frame has been fully drained, or abandoned because sort_vld dropped, the
//   block pulses sort_clear so the sorter can accept its next frame.
//
// Optional feature (compile-time macro SORT_DRAIN_REVERSE_EN):
//   - Adds input `rev`, which is sampled when a frame starts.
//   - With rev=1 the frame streams from entry NUM_NODES-1 down to entry 0.
//   - Without the macro there is no `rev` port and streaming is always
//     ascending.
//
// Ports:
//   clk, rst      : clock (rising edge) and asynchronous active-high reset
//   rev           : descending-order select (only with SORT_DRAIN_REVERSE_EN)
//   sort_vld      : sorter out_vld; the arrays are stable while it is high
//   sort_data     : sorter data_out, NUM_NODES+1 entries (last entry unused)
//   sort_idx      : sorter idx_out,  NUM_NODES+1 entries (last entry unused)
//   sort_clear    : one-cycle clear pulse back to the sorter
//   m_valid/m_ready/m_data/m_idx/m_last : output stream
//   busy          : state is not IDLE
//   err           : sticky; sort_vld dropped mid-stream
//   frame_cnt     : number of frames fully drained (wraps)
module sort_result_drain #(
  parameter int unsigned WIDTH     = 32,
  parameter int unsigned NUM_NODES = 16,
  parameter int unsigned IDX_W     = $clog2(NUM_NODES)
) (
  input  logic                                clk,
  input  logic                                rst,
`ifdef SORT_DRAIN_REVERSE_EN
  input  logic                                rev,
`endif
  input  logic                                sort_vld,
  input  logic [NUM_NODES:0][WIDTH-1:0]       sort_data,
  input  logic [NUM_NODES:0][IDX_W-1:0]       sort_idx,
  output logic                                sort_clear,
  output logic                                m_valid,
  input  logic                                m_ready,
  output logic [WIDTH-1:0]                    m_data,
  output logic [IDX_W-1:0]                    m_idx,
  output logic                                m_last,
  output logic                                busy,
  output logic                                err,
  output logic [15:0]                         frame_cnt
);

  // Index width needed to address the full NUM_NODES+1 entry input arrays.
  localparam int unsigned AW = $clog2(NUM_NODES + 1);
  localparam logic [IDX_W-1:0] LAST_PTR = IDX_W'(NUM_NODES - 1);

  localparam logic [1:0] IDLE     = 2'd0;
  localparam logic [1:0] STREAM   = 2'd1;
  localparam logic [1:0] CLEAR    = 2'd2;
  localparam logic [1:0] WAIT_LOW = 2'd3;

  logic [1:0]       state, state_n;
  logic [IDX_W-1:0] ptr, ptr_n;
  logic             m_valid_n, m_last_n;
  logic [WIDTH-1:0] m_data_n;
  logic [IDX_W-1:0] m_idx_n;
  logic             sort_clear_n, busy_n, err_n;
  logic [15:0]      frame_cnt_n;

  // Array entry loaded at frame start and on each non-final handshake.
  logic [IDX_W-1:0] first_addr;
  logic [IDX_W-1:0] next_addr;

  // The sorter's spare top entry is never streamed.
  logic unused_entries;
  assign unused_entries = ^{sort_data[NUM_NODES], sort_idx[NUM_NODES]};

`ifdef SORT_DRAIN_REVERSE_EN
  // Direction is latched at frame start so it cannot change mid-frame.
  logic rev_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rev_q <= 1'b0;
    end else if (state == IDLE && sort_vld) begin
      rev_q <= rev;
    end
  end

  // ptr always counts elements sent; the entry address is mirrored in reverse.
  assign first_addr = rev ? LAST_PTR : '0;
  assign next_addr  = rev_q ? (LAST_PTR - ptr) : ptr;
`else
  assign first_addr = '0;
  assign next_addr  = ptr;
`endif

  // State and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      ptr        <= '0;
      m_valid    <= 1'b0;
      m_last     <= 1'b0;
      m_data     <= '0;
      m_idx      <= '0;
      sort_clear <= 1'b0;
      busy       <= 1'b0;
      err        <= 1'b0;
      frame_cnt  <= '0;
    end else begin
      state      <= state_n;
      ptr        <= ptr_n;
      m_valid    <= m_valid_n;
      m_last     <= m_last_n;
      m_data     <= m_data_n;
      m_idx      <= m_idx_n;
      sort_clear <= sort_clear_n;
      busy       <= busy_n;
      err        <= err_n;
      frame_cnt  <= frame_cnt_n;
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    state_n     = state;
    ptr_n       = ptr;
    m_valid_n   = m_valid;
    m_last_n    = m_last;
    m_data_n    = m_data;
    m_idx_n     = m_idx;
    err_n       = err;
    frame_cnt_n = frame_cnt;

    case (state)
      IDLE: begin
        if (sort_vld) begin
          state_n   = STREAM;
          m_data_n  = sort_data[AW'(first_addr)];
          m_idx_n   = sort_idx[AW'(first_addr)];
          m_valid_n = 1'b1;
          // NUM_NODES >= 2, so the first element is never the last.
          m_last_n  = 1'b0;
          ptr_n     = IDX_W'(1);
        end
      end

      STREAM: begin
        if (!sort_vld) begin
          // Losing the source mid-frame wins over any handshake this cycle.
          err_n     = 1'b1;
          m_valid_n = 1'b0;
          m_last_n  = 1'b0;
          state_n   = CLEAR;
        end else if (m_valid && m_ready) begin
          if (m_last) begin
            m_valid_n   = 1'b0;
            m_last_n    = 1'b0;
            frame_cnt_n = frame_cnt + 16'd1;
            state_n     = CLEAR;
          end else begin
            m_data_n = sort_data[AW'(next_addr)];
            m_idx_n  = sort_idx[AW'(next_addr)];
            m_last_n = (ptr == LAST_PTR);
            ptr_n    = ptr + IDX_W'(1);
          end
        end
      end

      CLEAR: begin
        ptr_n   = '0;
        state_n = WAIT_LOW;
      end

      WAIT_LOW: begin
        // A valid still held from the drained frame must not restart it.
        if (!sort_vld) begin
          state_n = IDLE;
        end
      end

      default: begin
        state_n = IDLE;
      end
    endcase

    sort_clear_n = (state_n == CLEAR);
    busy_n       = (state_n != IDLE);
  end

endmodule

// File: doc/sort_result_drain.md
# sort_result_drain

Reads the parallel sorted result of `serial_sorter` (value array, index array, `out_vld`) and streams it out one (value, index) pair per cycle on a valid/ready interface. It is the draining end of the sorter: `serial_sorter` loads serially and presents results in parallel, and this block turns them back into a serial stream. When the stream completes, it pulses the sorter's `clear` so the sorter can accept the next frame. It sits between `serial_sorter` and any downstream consumer.

## Interface
- `WIDTH`, 32: width of one value.
- `NUM_NODES`, 16: entries per frame. Must be ≥ 2.
- `IDX_W`, `$clog2(NUM_NODES)`: index width. Matches the sorter's `idx_out`.
- `clk`, input, 1: clock. All logic is on the rising edge.
- `rst`, input, 1: asynchronous, active-high reset.
- `sort_vld`, input, 1: the sorter's `out_vld`. Arrays are stable while it is high.
- `sort_data`, input, `WIDTH` × (`NUM_NODES`+1): the sorter's `data_out`. Only entries 0..`NUM_NODES`-1 are used.
- `sort_idx`, input, `IDX_W` × (`NUM_NODES`+1): the sorter's `idx_out`. Only entries 0..`NUM_NODES`-1 are used.
- `sort_clear`, output, 1: one-cycle pulse to the sorter's `clear`.
- `m_valid`, output, 1: stream element valid.
- `m_ready`, input, 1: downstream accept.
- `m_data`, output, `WIDTH`: element value.
- `m_idx`, output, `IDX_W`: original input position of the element.
- `m_last`, output, 1: final element of the frame.
- `busy`, output, 1: high whenever the state is not IDLE.
- `err`, output, 1: sticky flag. Set when `sort_vld` drops mid-stream. Cleared only by `rst`.
- `frame_cnt`, output, 16: count of frames fully drained. Wraps from 0xFFFF to 0.

## Operation
- States:
  - IDLE: wait for a frame.
  - STREAM: send elements.
  - CLEAR: pulse `sort_clear`.
  - WAIT_LOW: wait for the sorter to drop `sort_vld`.
- Pointer `ptr` is `IDX_W` bits wide and counts 0..`NUM_NODES`-1.
- IDLE → STREAM when `sort_vld`=1 is sampled:
  - load `m_data`=`sort_data[0]`, `m_idx`=`sort_idx[0]`;
  - set `m_valid`=1, `ptr`=1;
  - set `m_last`=1 only if `NUM_NODES`=1. This cannot occur because `NUM_NODES` ≥ 2, so it is always 0.
- STREAM, handshake (`m_valid`&`m_ready`) with `m_last`=0:
  - load element `ptr` into the output registers;
  - increment `ptr`;
  - `m_last` becomes 1 when the loaded element is entry `NUM_NODES`-1.
- STREAM, no handshake: all `m_*` outputs hold their values.
- STREAM, handshake with `m_last`=1:
  - `m_valid`, `m_last` ← 0;
  - increment `frame_cnt`;
  - go to CLEAR.
- STREAM with `sort_vld`=0 sampled:
  - set `err`;
  - `m_valid`, `m_last` ← 0, dropping any pending element;
  - go to CLEAR without incrementing `frame_cnt`.
  - If a handshake happens in the same cycle, the error takes priority.
- CLEAR: `sort_clear`=1 for exactly this one cycle, then go to WAIT_LOW.
- WAIT_LOW: go to IDLE in the first cycle `sort_vld`=0 is sampled. A stale `out_vld` therefore never starts a second frame.
- Reset values, all asserted while `rst` is high:
  - `m_valid`, `m_last`, `m_data`, `m_idx` = 0;
  - `sort_clear`, `busy`, `err` = 0;
  - `frame_cnt` = 0;
  - state = IDLE, `ptr` = 0.
- Reset mid-frame: no `sort_clear` pulse is generated and the frame is abandoned. The sorter must be cleared or reset by its owner.

## Timing
- Latency: `sort_vld` sampled high at edge N → `m_valid`=1 and element 0 present after edge N.
- Throughput: one element per cycle while `m_ready`=1. A full frame takes `NUM_NODES` cycles.
- `sort_clear` is high in the cycle after the last handshake.
- Earliest next frame start: the edge after `sort_vld` is seen low in WAIT_LOW.
- `m_valid` never deasserts without a handshake, except on `err` or `rst`.
- Outputs are registered, with no combinational path from `m_ready` to any output.

## Configuration
- Macro `SORT_DRAIN_REVERSE_EN`.
- When defined:
  - a port `rev` (input, 1) is added;
  - `rev` is sampled on the IDLE → STREAM transition;
  - with `rev`=1, elements stream from entry `NUM_NODES`-1 down to 0, giving descending order;
  - `m_last` is set on entry 0.
- When undefined: no `rev` port; streaming is always ascending, entry 0 to `NUM_NODES`-1.

## Test plan
All scenarios use `NUM_NODES`=4, `WIDTH`=8.
- Basic drain: sorted data {3,7,7,9}, idx {2,3,0,1}, `sort_vld`=1, `m_ready`=1.
  - Stream (3,2),(7,3),(7,0),(9,1) in 4 consecutive cycles, `m_last` on the 4th.
  - One `sort_clear` pulse, then `frame_cnt`=1.
- Backpressure: same frame with `m_ready` toggling 1,0,0,1,0,1,1.
  - Each element holds stable across stalls; exact order preserved; 4 handshakes total.
- Mid-stream drop: `sort_vld` falls after 2 handshakes.
  - `err`=1, `m_valid`=0 next cycle, `sort_clear` pulses, `frame_cnt` unchanged.
- Stale valid: `sort_vld` held high for 5 cycles after `sort_clear`.
  - Block stays in WAIT_LOW with `m_valid`=0.
  - A new frame starts only after `sort_vld` has dropped and then risen again.
- Reset mid-frame: assert `rst` after 1 handshake.
  - All outputs go to 0 asynchronously, with no `sort_clear`.
  - After release, a new frame drains correctly.
- Reverse, with `SORT_DRAIN_REVERSE_EN` defined: `rev`=1 with the basic-drain frame.
  - Stream (9,1),(7,0),(7,3),(3,2), `m_last` on (3,2).
